yuv_rgb_frame_writer: RTL

Colour-space conversion stage directly upstream of the VGA SRAM display path. Reads a 320x240 YUV 4:2:2 frame from the shared 256K x 16 SRAM, converts it to 8-bit RGB in fixed point, and writes it back as packed RGB at `RGB_BASE`. The VGA reader then fetches this RGB region (3 words per 2 pixels) and displays it. Runs once per `start` pulse and owns the SRAM port while `busy` is high.

---
 rtl/yuv_rgb_frame_writer.sv | 240 ++++++++++++++++++++++++
 1 files changed

// File: rtl/yuv_rgb_frame_writer.sv
`timescale 1ns/1ps
// Converts one YUV 4:2:2 frame in SRAM to packed 8-bit RGB, 13 cycles per 4-pixel group.
// SRAM reads return two cycles after the address; all SRAM outputs are registered.
module yuv_rgb_frame_writer #(
  parameter logic [17:0] Y_BASE     = 18'd0,
  parameter logic [17:0] U_BASE     = 18'd38400,
  parameter logic [17:0] V_BASE     = 18'd57600,
  parameter logic [17:0] RGB_BASE   = 18'd146944,
  parameter int          NUM_GROUPS = 19200
) (
  input  logic        Clock,
  input  logic        Resetn,
  input  logic        start,
  output logic        busy,
  output logic        done,
  output logic [17:0] SRAM_address,
  output logic [15:0] SRAM_write_data,
  output logic        SRAM_we_n,
  input  logic [15:0] SRAM_read_data
);

  localparam int            KW     = (NUM_GROUPS > 1) ? $clog2(NUM_GROUPS) : 1;
  localparam logic [KW-1:0] K_LAST = KW'(NUM_GROUPS - 1);

  typedef enum logic [3:0] {
    S_IDLE,
    S_RD0,
    S_RD1,
    S_RD2,
    S_RD3,
    S_CAP_U,
    S_CAP_V,
    S_CALC,
    S_WR0,
    S_WR1,
    S_WR2,
    S_WR3,
    S_WR4,
    S_WR5
  } state_t;

  state_t        r_state;
  state_t        w_state_nxt;
  logic [KW-1:0] r_k;
  logic [KW-1:0] w_k_nxt;
  logic [17:0]   w_k18;
  logic [17:0]   w_k_nxt18;

  logic [17:0]   w_addr_nxt;
  logic [15:0]   w_wdata_nxt;
  logic          w_we_n_nxt;
  logic          w_busy_nxt;
  logic          w_done_nxt;

  logic [15:0]   r_y01;
  logic [15:0]   r_y23;
  logic [15:0]   r_u;
  logic [15:0]   r_v;
  logic [23:0]   r_p0;
  logic [23:0]   r_p1;
  logic [23:0]   r_p2;
  logic [23:0]   r_p3;
  logic [23:0]   w_p0;
  logic [23:0]   w_p1;
  logic [23:0]   w_p2;
  logic [23:0]   w_p3;

  // Arithmetic shift floors negative sums, so anything below zero clips to 0.
  function automatic logic [7:0] clip16(input logic signed [31:0] acc);
    logic signed [31:0] s;
    s = acc >>> 16;
    if (s < 0)
      return 8'd0;
    if (s > 32'sd255)
      return 8'hFF;
    return s[7:0];
  endfunction

  function automatic logic [23:0] yuv2rgb(input logic [7:0] yb,
                                          input logic [7:0] ub,
                                          input logic [7:0] vb);
    logic signed [31:0] y;
    logic signed [31:0] u;
    logic signed [31:0] v;
    logic signed [31:0] r;
    logic signed [31:0] g;
    logic signed [31:0] b;
    y = signed'({24'd0, yb}) - 32'sd16;
    u = signed'({24'd0, ub}) - 32'sd128;
    v = signed'({24'd0, vb}) - 32'sd128;
    r = 32'sd76284 * y + 32'sd104595 * v;
    g = 32'sd76284 * y - 32'sd25624 * u - 32'sd53281 * v;
    b = 32'sd76284 * y + 32'sd132251 * u;
    return {clip16(r), clip16(g), clip16(b)};
  endfunction

  // High bytes are the even pixel / first chroma pair.
  assign w_p0 = yuv2rgb(r_y01[15:8], r_u[15:8], r_v[15:8]);
  assign w_p1 = yuv2rgb(r_y01[7:0],  r_u[15:8], r_v[15:8]);
  assign w_p2 = yuv2rgb(r_y23[15:8], r_u[7:0],  r_v[7:0]);
  assign w_p3 = yuv2rgb(r_y23[7:0],  r_u[7:0],  r_v[7:0]);

  assign w_k18     = 18'(r_k);
  assign w_k_nxt18 = 18'(w_k_nxt);

  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      r_state         <= S_IDLE;
      r_k             <= '0;
      busy            <= 1'b0;
      done            <= 1'b0;
      SRAM_address    <= '0;
      SRAM_write_data <= '0;
      SRAM_we_n       <= 1'b1;
    end else begin
      r_state         <= w_state_nxt;
      r_k             <= w_k_nxt;
      busy            <= w_busy_nxt;
      done            <= w_done_nxt;
      SRAM_address    <= w_addr_nxt;
      SRAM_write_data <= w_wdata_nxt;
      SRAM_we_n       <= w_we_n_nxt;
    end
  end

  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      r_y01 <= '0;
      r_y23 <= '0;
      r_u   <= '0;
      r_v   <= '0;
      r_p0  <= '0;
      r_p1  <= '0;
      r_p2  <= '0;
      r_p3  <= '0;
    end else begin
      case (r_state)
        S_RD2:   r_y01 <= SRAM_read_data;
        S_RD3:   r_y23 <= SRAM_read_data;
        S_CAP_U: r_u   <= SRAM_read_data;
        S_CAP_V: r_v   <= SRAM_read_data;
        S_CALC: begin
          r_p0 <= w_p0;
          r_p1 <= w_p1;
          r_p2 <= w_p2;
          r_p3 <= w_p3;
        end
        default: ;
      endcase
    end
  end

  // Next values for the registered SRAM outputs are chosen by the state being entered.
  always_comb begin
    w_state_nxt = r_state;
    w_k_nxt     = r_k;
    w_addr_nxt  = SRAM_address;
    w_wdata_nxt = SRAM_write_data;
    w_we_n_nxt  = 1'b1;
    w_busy_nxt  = busy;
    w_done_nxt  = 1'b0;

    case (r_state)
      S_IDLE: begin
        if (start && !busy) begin
          w_state_nxt = S_RD0;
          w_addr_nxt  = Y_BASE + (w_k18 << 1);
          w_busy_nxt  = 1'b1;
        end else begin
          w_busy_nxt  = 1'b0;
        end
      end
      S_RD0: begin
        w_state_nxt = S_RD1;
        w_addr_nxt  = Y_BASE + (w_k18 << 1) + 18'd1;
      end
      S_RD1: begin
        w_state_nxt = S_RD2;
        w_addr_nxt  = U_BASE + w_k18;
      end
      S_RD2: begin
        w_state_nxt = S_RD3;
        w_addr_nxt  = V_BASE + w_k18;
      end
      S_RD3:   w_state_nxt = S_CAP_U;
      S_CAP_U: w_state_nxt = S_CAP_V;
      S_CAP_V: w_state_nxt = S_CALC;
      S_CALC: begin
        w_state_nxt = S_WR0;
        w_addr_nxt  = RGB_BASE + (w_k18 << 2) + (w_k18 << 1);
        w_wdata_nxt = w_p0[23:8];
        w_we_n_nxt  = 1'b0;
      end
      S_WR0: begin
        w_state_nxt = S_WR1;
        w_addr_nxt  = SRAM_address + 18'd1;
        w_wdata_nxt = {r_p0[7:0], r_p1[23:16]};
        w_we_n_nxt  = 1'b0;
      end
      S_WR1: begin
        w_state_nxt = S_WR2;
        w_addr_nxt  = SRAM_address + 18'd1;
        w_wdata_nxt = r_p1[15:0];
        w_we_n_nxt  = 1'b0;
      end
      S_WR2: begin
        w_state_nxt = S_WR3;
        w_addr_nxt  = SRAM_address + 18'd1;
        w_wdata_nxt = r_p2[23:8];
        w_we_n_nxt  = 1'b0;
      end
      S_WR3: begin
        w_state_nxt = S_WR4;
        w_addr_nxt  = SRAM_address + 18'd1;
        w_wdata_nxt = {r_p2[7:0], r_p3[23:16]};
        w_we_n_nxt  = 1'b0;
      end
      S_WR4: begin
        w_state_nxt = S_WR5;
        w_addr_nxt  = SRAM_address + 18'd1;
        w_wdata_nxt = r_p3[15:0];
        w_we_n_nxt  = 1'b0;
      end
      S_WR5: begin
        if (r_k < K_LAST) begin
          w_k_nxt     = r_k + KW'(1);
          w_state_nxt = S_RD0;
          w_addr_nxt  = Y_BASE + (w_k_nxt18 << 1);
        end else begin
          // busy stays high through the done cycle and drops with it.
          w_k_nxt     = '0;
          w_state_nxt = S_IDLE;
          w_done_nxt  = 1'b1;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

endmodule
